fir_seq_ctrl: RTL

Sequencer that feeds the FIR filter one sample at a time. Requesters push 8-bit samples through a valid/ready port into a small FIFO. The controller loads each sample onto the FIR input, pulses go, waits the filter latency and captures the 16-bit result into a valid/ready output register. It sits between the sample source (switches or an upstream block) and the FIR datapath, and replaces manual in/go/rst driving.

---
 rtl/fir_seq_ctrl.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/fir_seq_ctrl.sv
// Sample sequencer for the FIR datapath: input FIFO, load/go/wait/capture FSM
// and a valid/ready result register with a running result count.
module fir_seq_ctrl #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned FIR_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        s_valid,
  input  logic [7:0]  s_data,
  output logic        s_ready,
  output logic [7:0]  fir_in,
  output logic        fir_go,
  output logic        fir_rst,
  input  logic [15:0] fir_y,
  output logic        m_valid,
  output logic [15:0] m_data,
  input  logic        m_ready,
  output logic        busy,
  output logic [15:0] sample_cnt
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned LW = (FIR_LAT > 1) ? $clog2(FIR_LAT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_GO,
    S_WAIT,
    S_CAPTURE
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [LW-1:0]   wait_q, wait_d;
  logic [7:0]      fir_in_q, fir_in_d;
  logic            m_valid_q, m_valid_d;
  logic [15:0]     m_data_q, m_data_d;
  logic [15:0]     cnt_q, cnt_d;
  logic            push, pop, full;

  assign full    = (count_q == CW'(DEPTH));
  assign s_ready = !full;
  assign push    = s_valid && !full;
  assign pop     = (state_q == S_LOAD);

  // FIFO bookkeeping; pointers wrap naturally since DEPTH is a power of two
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (!push && pop) count_d = count_q - CW'(1);
  end

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    fir_in_d  = fir_in_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    cnt_d     = cnt_q;
    fir_go    = 1'b0;
    if (m_valid_q && m_ready) m_valid_d = 1'b0;
    case (state_q)
      // Leaving IDLE on the edge that drains the result register keeps throughput at FIR_LAT+4
      S_IDLE: begin
        if ((count_q != '0) && (!m_valid_q || m_ready)) state_d = S_LOAD;
      end
      S_LOAD: begin
        fir_in_d = mem_q[rd_ptr_q];
        state_d  = S_GO;
      end
      S_GO: begin
        fir_go  = 1'b1;
        wait_d  = LW'(FIR_LAT - 1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (wait_q == '0) state_d = S_CAPTURE;
        else              wait_d  = wait_q - LW'(1);
      end
      S_CAPTURE: begin
        m_data_d  = fir_y;
        m_valid_d = 1'b1;
        cnt_d     = cnt_q + 16'd1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush && push) mem_q[wr_ptr_q] <= s_data;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      wait_q    <= '0;
      fir_in_q  <= '0;
      m_valid_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      wait_q    <= wait_d;
      fir_in_q  <= fir_in_d;
      m_valid_q <= m_valid_d;
      cnt_q     <= cnt_d;
    end
  end

  // A flush leaves the last result visible in m_data
  always_ff @(posedge clk) begin
    if (rst)         m_data_q <= '0;
    else if (!flush) m_data_q <= m_data_d;
  end

  assign fir_in     = fir_in_q;
  assign fir_rst    = rst | flush;
  assign m_valid    = m_valid_q;
  assign m_data     = m_data_q;
  assign busy       = (state_q != S_IDLE);
  assign sample_cnt = cnt_q;

endmodule
